rename_sched: RTL

Allocation controller for the 32-entry rename tag pool. Hands out physical rename tags to the two dispatch lanes in program order, takes tags back from the commit stage, and sequences a multi-cycle pool reclaim after a pipeline flush. Sits between decode/dispatch and the rename tag storage; it is the only agent that sets or clears the pool's in-use bits.

---
 rtl/rename_sched_pkg.sv | 19 +
 rtl/rename_sched_tag_picker.sv | 46 ++++
 rtl/rename_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rename_sched_pkg.sv
// Shared types and helpers for the rename tag allocation controller.
package rename_sched_pkg;

    localparam int TAG_W = 6;
    localparam int IDX_W = TAG_W - 1;

    typedef logic [TAG_W-1:0] rename_tag_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } sched_state_t;

    // Rename tags live above the architectural registers: bit5 marks a rename tag.
    function automatic rename_tag_t make_tag(input logic [IDX_W-1:0] idx);
        return {1'b1, idx};
    endfunction

endpackage

// File: rtl/rename_sched_tag_picker.sv
// Combinational priority picker: lowest and second-lowest set bit of a free vector.
module rename_sched_tag_picker
    import rename_sched_pkg::*;
#(
    parameter int TAGS = 32
)(
    input  logic [TAGS-1:0]  free_vec,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_found,
    output logic [IDX_W-1:0] second_idx,
    output logic             second_found
);

    logic [TAGS-1:0] rest_s;

    // Scan downward so the last hit is the lowest index; mask it and scan again.
    always_comb begin
        first_idx    = '0;
        first_found  = 1'b0;
        second_idx   = '0;
        second_found = 1'b0;
        rest_s       = free_vec;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                first_idx   = IDX_W'(i);
                first_found = 1'b1;
            end else begin
                first_idx   = first_idx;
            end
        end
        if (first_found) begin
            rest_s[first_idx] = 1'b0;
        end else begin
            rest_s = free_vec;
        end
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (rest_s[i]) begin
                second_idx   = IDX_W'(i);
                second_found = 1'b1;
            end else begin
                second_idx   = second_idx;
            end
        end
    end

endmodule

// File: rtl/rename_sched.sv
// Rename tag pool allocation controller: in-order two-lane allocation,
// commit-stage release and multi-cycle pool reclaim after a flush.
// Optional feature macro: RENAME_SCHED_STATS_EN adds the stall_cycles counter.
module rename_sched
    import rename_sched_pkg::*;
#(
    parameter int TAGS            = 32,
    parameter int CLEAR_PER_CYCLE = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       grant,
    output rename_tag_t      tag [2],
    output logic             stall,
    input  logic [1:0]       release_valid,
    input  rename_tag_t      release_tag [2],
    input  logic             flush,
    output logic             busy,
    output logic [IDX_W:0]   free_count
`ifdef RENAME_SCHED_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    sched_state_t     state_r, state_next_s;
    logic [IDX_W-1:0] clr_idx_r, clr_idx_next_s;
    logic [TAGS-1:0]  in_use_r, in_use_next_s;
    logic [TAGS-1:0]  set_mask_s, rel_mask_s, grp_mask_s;
    logic [1:0]       grant_next_s;
    rename_tag_t      tag_next_s [2];
    logic             stall_next_s;
    logic [IDX_W:0]   used_cnt_s;
    logic [IDX_W-1:0] first_idx_s, second_idx_s;
    logic             first_found_s, second_found_s;

    rename_sched_tag_picker #(.TAGS(TAGS)) u_picker (
        .free_vec     (~in_use_r),
        .first_idx    (first_idx_s),
        .first_found  (first_found_s),
        .second_idx   (second_idx_s),
        .second_found (second_found_s)
    );

    // Next-state, bitmap update and next registered outputs.
    always_comb begin
        state_next_s   = state_r;
        clr_idx_next_s = clr_idx_r;
        in_use_next_s  = in_use_r;
        set_mask_s     = '0;
        rel_mask_s     = '0;
        grp_mask_s     = '0;
        grant_next_s   = 2'b00;
        tag_next_s[0]  = '0;
        tag_next_s[1]  = '0;
        stall_next_s   = 1'b0;
        if (flush) begin
            // Flush wins in any state: no grants, releases dropped, walk restarts.
            state_next_s   = RECOVER;
            clr_idx_next_s = '0;
            stall_next_s   = |req;
        end else begin
            case (state_r)
                RUN: begin
                    if (req[0] && first_found_s) begin
                        grant_next_s[0]         = 1'b1;
                        tag_next_s[0]           = make_tag(first_idx_s);
                        set_mask_s[first_idx_s] = 1'b1;
                    end else begin
                        grant_next_s[0] = 1'b0;
                    end
                    // Lane 1 never overtakes a stalled lane 0.
                    if (req[1] && req[0]) begin
                        if (grant_next_s[0] && second_found_s) begin
                            grant_next_s[1]          = 1'b1;
                            tag_next_s[1]            = make_tag(second_idx_s);
                            set_mask_s[second_idx_s] = 1'b1;
                        end else begin
                            grant_next_s[1] = 1'b0;
                        end
                    end else if (req[1]) begin
                        if (first_found_s) begin
                            grant_next_s[1]         = 1'b1;
                            tag_next_s[1]           = make_tag(first_idx_s);
                            set_mask_s[first_idx_s] = 1'b1;
                        end else begin
                            grant_next_s[1] = 1'b0;
                        end
                    end else begin
                        grant_next_s[1] = 1'b0;
                    end
                    for (int r = 0; r < 2; r++) begin
                        if (release_valid[r] && release_tag[r][TAG_W-1]) begin
                            rel_mask_s[release_tag[r][IDX_W-1:0]] = 1'b1;
                        end else begin
                            rel_mask_s = rel_mask_s;
                        end
                    end
                    // Clear before set: releasing an already-free tag must not undo a new grant.
                    in_use_next_s = (in_use_r & ~rel_mask_s) | set_mask_s;
                    stall_next_s  = (req[0] & ~grant_next_s[0]) | (req[1] & ~grant_next_s[1]);
                end
                RECOVER: begin
                    stall_next_s = |req;
                    for (int i = 0; i < CLEAR_PER_CYCLE; i++) begin
                        grp_mask_s[clr_idx_r + IDX_W'(i)] = 1'b1;
                    end
                    in_use_next_s = in_use_r & ~grp_mask_s;
                    if (clr_idx_r == IDX_W'(TAGS - CLEAR_PER_CYCLE)) begin
                        state_next_s   = RUN;
                        clr_idx_next_s = '0;
                    end else begin
                        clr_idx_next_s = clr_idx_r + IDX_W'(CLEAR_PER_CYCLE);
                    end
                end
                default: begin
                    state_next_s   = RUN;
                    clr_idx_next_s = '0;
                end
            endcase
        end
    end

    // Population count of the post-update bitmap for free_count.
    always_comb begin
        used_cnt_s = '0;
        for (int i = 0; i < TAGS; i++) begin
            used_cnt_s = used_cnt_s + (IDX_W+1)'(in_use_next_s[i]);
        end
    end

    // State, bitmap and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= RUN;
            clr_idx_r  <= '0;
            in_use_r   <= '0;
            grant      <= 2'b00;
            tag[0]     <= '0;
            tag[1]     <= '0;
            stall      <= 1'b0;
            busy       <= 1'b0;
            free_count <= (IDX_W+1)'(TAGS);
        end else begin
            state_r    <= state_next_s;
            clr_idx_r  <= clr_idx_next_s;
            in_use_r   <= in_use_next_s;
            grant      <= grant_next_s;
            tag[0]     <= tag_next_s[0];
            tag[1]     <= tag_next_s[1];
            stall      <= stall_next_s;
            busy       <= (state_next_s == RECOVER);
            free_count <= (IDX_W+1)'(TAGS) - used_cnt_s;
        end
    end

`ifdef RENAME_SCHED_STATS_EN
    // Saturating count of cycles with stall asserted; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule
